// File: rtl/output_selector.sv
// ============================================================================
// Module   : output_selector
// Brief    : Routes an 8-bit stream into one of two single-word output slots,
//            with per-slot valid/ack handshake and accept counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module output_selector (
   input  logic       clk,
   input  logic       rst,
   input  logic       swc,
   input  logic [7:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out0,
   output logic       out0_valid,
   input  logic       out0_ack,
   output logic [7:0] out1,
   output logic       out1_valid,
   input  logic       out1_ack,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;

   slot_state_t st0_q, st0_d;
   slot_state_t st1_q, st1_d;
   logic [7:0]  data0_q, data0_d;
   logic [7:0]  data1_q, data1_d;
   logic [7:0]  cnt0_q, cnt0_d;
   logic [7:0]  cnt1_q, cnt1_d;

   logic w_sel_full;
   logic w_sel_ack;
   logic w_accept;
   logic w_wr0;
   logic w_wr1;
   logic w_drain0;
   logic w_drain1;

   // A full slot can take a new word only in the cycle its consumer empties it.
   assign w_sel_full = swc ? (st1_q == ST_FULL) : (st0_q == ST_FULL);
   assign w_sel_ack  = swc ? out1_ack : out0_ack;
   assign in_ready   = ~w_sel_full | w_sel_ack;
   assign w_accept   = in_valid & in_ready;
   assign w_wr0      = w_accept & ~swc;
   assign w_wr1      = w_accept &  swc;
   assign w_drain0   = (st0_q == ST_FULL) & out0_ack;
   assign w_drain1   = (st1_q == ST_FULL) & out1_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st0_q   <= ST_EMPTY;
         st1_q   <= ST_EMPTY;
         data0_q <= 8'h00;
         data1_q <= 8'h00;
         cnt0_q  <= 8'h00;
         cnt1_q  <= 8'h00;
      end else begin
         st0_q   <= st0_d;
         st1_q   <= st1_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   always_comb begin
      st0_d   = st0_q;
      st1_d   = st1_q;
      data0_d = data0_q;
      data1_d = data1_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;

      case (st0_q)
         ST_EMPTY: if (w_wr0) st0_d = ST_FULL;
         ST_FULL:  if (w_drain0 && !w_wr0) st0_d = ST_EMPTY;
         default:  st0_d = ST_EMPTY;
      endcase

      case (st1_q)
         ST_EMPTY: if (w_wr1) st1_d = ST_FULL;
         ST_FULL:  if (w_drain1 && !w_wr1) st1_d = ST_EMPTY;
         default:  st1_d = ST_EMPTY;
      endcase

      // Data holds its last value after a drain; only a write replaces it.
      if (w_wr0) begin
         data0_d = in;
         cnt0_d  = cnt0_q + 8'd1;
      end
      if (w_wr1) begin
         data1_d = in;
         cnt1_d  = cnt1_q + 8'd1;
      end
   end

   assign out0       = data0_q;
   assign out1       = data1_q;
   assign out0_valid = (st0_q == ST_FULL);
   assign out1_valid = (st1_q == ST_FULL);
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_output_selector.sv
// ============================================================================
// Module   : tb_output_selector
// Brief    : Self-checking bench for output_selector: reference model with
//            per-slot scoreboards plus directed scenarios.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_output_selector;

   logic       clk;
   logic       rst;
   logic       swc;
   logic [7:0] in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out0;
   logic       out0_valid;
   logic       out0_ack;
   logic [7:0] out1;
   logic       out1_valid;
   logic       out1_ack;
   logic [7:0] cnt0;
   logic [7:0] cnt1;

   int n_checks = 0;
   int n_errs   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   logic       m_v0, m_v1;
   logic [7:0] m_d0, m_d1;
   logic [7:0] m_c0, m_c1;

   output_selector dut (
      .clk        (clk),
      .rst        (rst),
      .swc        (swc),
      .in         (in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0       (out0),
      .out0_valid (out0_valid),
      .out0_ack   (out0_ack),
      .out1       (out1),
      .out1_valid (out1_valid),
      .out1_ack   (out1_ack),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic [7:0] d, input logic v,
                        input logic a0, input logic a1);
      swc      = s;
      in       = d;
      in_valid = v;
      out0_ack = a0;
      out1_ack = a1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: checked and advanced on the falling edge, while inputs are stable.
   always @(negedge clk) begin
      logic       exp_ready, acc, dr0, dr1;
      logic [7:0] popped;
      if (rst) begin
         m_v0 = 1'b0; m_v1 = 1'b0;
         m_d0 = 8'h00; m_d1 = 8'h00;
         m_c0 = 8'h00; m_c1 = 8'h00;
         q0.delete();
         q1.delete();
         chk("rst_out0", out0, 8'h00);
         chk("rst_out1", out1, 8'h00);
         chk("rst_v0", out0_valid, 1'b0);
         chk("rst_v1", out1_valid, 1'b0);
         chk("rst_ready", in_ready, 1'b1);
      end else begin
         chk("m_v0", out0_valid, m_v0);
         chk("m_v1", out1_valid, m_v1);
         chk("m_d0", out0, m_d0);
         chk("m_d1", out1, m_d1);
         chk("m_c0", cnt0, m_c0);
         chk("m_c1", cnt1, m_c1);
         exp_ready = swc ? (~m_v1 | out1_ack) : (~m_v0 | out0_ack);
         chk("m_ready", in_ready, exp_ready);
         acc = in_valid & exp_ready;
         dr0 = m_v0 & out0_ack;
         dr1 = m_v1 & out1_ack;
         if (dr0) begin
            if (q0.size() == 0) chk("sb0_underflow", 32'd0, 32'd1);
            else begin
               popped = q0.pop_front();
               chk("sb0_drain", out0, popped);
            end
         end
         if (dr1) begin
            if (q1.size() == 0) chk("sb1_underflow", 32'd0, 32'd1);
            else begin
               popped = q1.pop_front();
               chk("sb1_drain", out1, popped);
            end
         end
         if (acc && !swc) begin
            q0.push_back(in);
            m_d0 = in; m_v0 = 1'b1; m_c0 = m_c0 + 8'd1;
         end else if (dr0) m_v0 = 1'b0;
         if (acc && swc) begin
            q1.push_back(in);
            m_d1 = in; m_v1 = 1'b1; m_c1 = m_c1 + 8'd1;
         end else if (dr1) m_v1 = 1'b0;
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2;
      chk("reset_ready", in_ready, 1'b1);
      chk("reset_cnt0", cnt0, 8'h00);
      step();
      step();
      rst = 1'b0;

      // Basic route
      drive(1'b0, 8'h05, 1'b1, 1'b0, 0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("basic_out0", out0, 8'h05);
      chk("basic_v0", out0_valid, 1'b1);
      chk("basic_cnt0", cnt0, 8'd1);
      chk("basic_v1", out1_valid, 1'b0);
      chk("basic_cnt1", cnt1, 8'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();

      // Back-pressure on slot 1
      drive(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
      #1;
      chk("bp_ready_low", in_ready, 1'b0);
      step();
      chk("bp_hold_out1", out1, 8'h10);
      chk("bp_hold_cnt1", cnt1, 8'd1);
      drive(1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
      #1;
      chk("bp_ready_ack", in_ready, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("bp_out1", out1, 8'h08);
      chk("bp_v1", out1_valid, 1'b1);
      chk("bp_cnt1", cnt1, 8'd2);

      // Drain slot 0 without write; slot 1 keeps its word meanwhile
      drive(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      chk("drain_v0", out0_valid, 1'b0);
      chk("drain_out0", out0, 8'hFF);
      chk("drain_keep_v1", out1_valid, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step();

      // Dual slots drained in the same cycle
      drive(1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("dual_v0_pre", out0_valid, 1'b1);
      chk("dual_v1_pre", out1_valid, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("dual_v0_post", out0_valid, 1'b0);
      chk("dual_v1_post", out1_valid, 1'b0);

      // Async reset between edges with both slots full
      drive(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out0", out0, 8'h00);
      chk("arst_out1", out1, 8'h00);
      chk("arst_v0", out0_valid, 1'b0);
      chk("arst_v1", out1_valid, 1'b0);
      chk("arst_cnt0", cnt0, 8'h00);
      chk("arst_cnt1", cnt1, 8'h00);
      chk("arst_ready", in_ready, 1'b1);
      step();
      rst = 1'b0;

      // Counter wrap: 256 accepts to slot 0 with continuous ack
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
         step();
         if (i == 0)   chk("first_accept_cnt0", cnt0, 8'd1);
         if (i == 127) chk("mid_cnt0", cnt0, 8'd128);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("wrap_cnt0", cnt0, 8'h00);
      chk("wrap_cnt1", cnt1, 8'h00);
      chk("wrap_out0", out0, 8'hFF);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      chk("sb0_empty", q0.size(), 32'd0);
      chk("sb1_empty", q1.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/output_selector.md
OUTPUT_SELECTOR -- requirements
Module: output_selector

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 The block SHALL have one clock, `clk`, and its reset SHALL be asynchronous and active-high, named `rst`.
REQ-003 Ports SHALL be as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- swc  input  1  destination select: 0 -> slot 0, 1 -> slot 1
- in  input  8  data to route
- in_valid  input  1  producer offers `in` this cycle
- in_ready  output  1  block accepts `in` this cycle (combinational)
- out0  output  8  slot 0 data register
- out0_valid  output  1  slot 0 holds unconsumed data
- out0_ack  input  1  consumer of slot 0 takes data this cycle
- out1  output  8  slot 1 data register
- out1_valid  output  1  slot 1 holds unconsumed data
- out1_ack  input  1  consumer of slot 1 takes data this cycle
- cnt0  output  8  count of words accepted into slot 0
- cnt1  output  8  count of words accepted into slot 1

Function
REQ-004 Slot k SHALL be "drained" in a cycle when outk_valid=1 and outk_ack=1.
REQ-005 in_ready SHALL equal (~outS_valid | outS_ack), where S=swc, evaluated combinationally in the same cycle.
REQ-006 An "accept" SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-007 On accept, the block SHALL load `in` into outS and set outS_valid=1 at that edge, giving 1-cycle latency from accept to visible data.
REQ-008 On accept, cntS SHALL increment by 1 at that edge, wrapping from 8'hFF to 8'h00.
REQ-009 If slot k is drained and not written in the same cycle, outk_valid SHALL clear to 0 and outk SHALL hold its last value.
REQ-010 If slot k is drained and written in the same cycle, outk_valid SHALL remain 1 and outk SHALL take the new `in`.
REQ-011 An outk_ack with outk_valid=0 SHALL be ignored, with no state change.
REQ-012 While in_valid=1 and in_ready=0, the block SHALL make no change to either slot or either counter; the producer holds.
REQ-013 The non-selected slot SHALL be unaffected by an accept, so both slots may be valid simultaneously.
REQ-014 Slot 0 and slot 1 SHALL drain independently in the same cycle.
REQ-015 swc SHALL be sampled only at the accepting edge; changing swc while stalled SHALL retarget the request, and in_ready SHALL recompute for the new slot.
REQ-016 Per slot, the block SHALL implement the state machine EMPTY <-> FULL:
- EMPTY -> FULL on write
- FULL -> EMPTY on drain without write
- FULL -> FULL on drain with write
- no other transitions

Reset
REQ-017 While rst=1, out0, out1, cnt0 and cnt1 SHALL be 8'h00, and out0_valid and out1_valid SHALL be 0, independent of clk.
REQ-018 While rst=1, in_ready SHALL be 1 and no accept SHALL be counted.
REQ-019 Reset asserted mid-transfer SHALL discard held data immediately.
REQ-020 After rst deasserts, the first accept SHALL occur on the first rising edge with in_valid=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic route: swc=0, in=8'h05, in_valid=1 for one cycle -> next cycle out0=8'h05, out0_valid=1, cnt0=1; out1_valid=0, cnt1=0.
- Back-pressure: slot 1 full with 8'h10 and no ack; swc=1, in=8'h08, in_valid=1 -> in_ready=0, out1 stays 8'h10, cnt1 unchanged; assert out1_ack -> in_ready=1 that cycle, next cycle out1=8'h08, out1_valid=1.
- Drain: slot 0 valid with 8'hFF; out0_ack=1 and no write -> next cycle out0_valid=0, out0=8'hFF.
- Dual slots: write 8'h01 to slot 0, then 8'h02 to slot 1, then ack both in the same cycle -> both valid flags are 1 before the ack and both are 0 after.
- Counter wrap: 256 accepts to slot 0 with continuous ack -> cnt0 returns to 8'h00, cnt1=0.
- Async reset: assert rst between clock edges with both slots full -> outputs and counters read zero before the next edge; in_ready=1.
